// File: rtl/univ_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_reg
// Description : Parametrised multi-mode storage register. On each rising Clk
//               edge it holds, loads, shifts (logical, with serial input),
//               rotates, increments or decrements its contents.
//
// Ports       : Clk   - system clock, rising-edge active
//               Rst   - synchronous active-high reset (Q = RESET_VAL, Co = 0)
//               En    - enable; when low all state holds
//               Mode  - operation select
//                       000 hold, 001 load, 010 shl, 011 shr,
//                       100 rol, 101 ror, 110 inc, 111 dec
//               D     - parallel load data
//               SinL  - serial bit entering bit 0 on shift left
//               SinR  - serial bit entering bit WIDTH-1 on shift right
//               Q     - register contents
//               Qn    - bitwise complement of Q (combinational)
//               Co    - registered carry / borrow / shifted-out bit
//               Zero  - high when Q == 0 (combinational)
//
// Revision    : 1.0 - initial release
// ============================================================================
module univ_reg #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SinL,
    input  logic             SinR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Co,
    output logic             Zero
);

    localparam logic [2:0] c_HOLD = 3'b000;
    localparam logic [2:0] c_LOAD = 3'b001;
    localparam logic [2:0] c_SHL  = 3'b010;
    localparam logic [2:0] c_SHR  = 3'b011;
    localparam logic [2:0] c_ROL  = 3'b100;
    localparam logic [2:0] c_ROR  = 3'b101;
    localparam logic [2:0] c_INC  = 3'b110;
    localparam logic [2:0] c_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_co;

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_all_ones;
    logic             w_all_zero;

    // A single-bit register has no neighbour bits: the shift/rotate results
    // are built separately so no zero-width part-select is ever elaborated.
    generate
        if (WIDTH > 1) begin : g_wide
            assign w_shl = {r_q[WIDTH-2:0], SinL};
            assign w_shr = {SinR, r_q[WIDTH-1:1]};
            assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            assign w_ror = {r_q[0], r_q[WIDTH-1:1]};
        end else begin : g_narrow
            assign w_shl = SinL;
            assign w_shr = SinR;
            assign w_rol = r_q;
            assign w_ror = r_q;
        end
    endgenerate

    assign w_inc      = r_q + c_ONE;
    assign w_dec      = r_q - c_ONE;
    assign w_all_ones = &r_q;
    assign w_all_zero = ~|r_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_q  <= RESET_VAL;
            r_co <= 1'b0;
        end else if (En) begin
            case (Mode)
                c_HOLD: begin
                    r_q  <= r_q;
                    r_co <= r_co;
                end
                c_LOAD: begin
                    r_q  <= D;
                    r_co <= 1'b0;
                end
                c_SHL: begin
                    r_q  <= w_shl;
                    r_co <= r_q[WIDTH-1];
                end
                c_SHR: begin
                    r_q  <= w_shr;
                    r_co <= r_q[0];
                end
                c_ROL: begin
                    r_q  <= w_rol;
                    r_co <= r_q[WIDTH-1];
                end
                c_ROR: begin
                    r_q  <= w_ror;
                    r_co <= r_q[0];
                end
                // Carry flags the wrap from all-ones to zero.
                c_INC: begin
                    r_q  <= w_inc;
                    r_co <= w_all_ones;
                end
                // Borrow flags the wrap from zero to all-ones.
                c_DEC: begin
                    r_q  <= w_dec;
                    r_co <= w_all_zero;
                end
                default: begin
                    r_q  <= r_q;
                    r_co <= r_co;
                end
            endcase
        end
    end

    assign Q    = r_q;
    assign Qn   = ~r_q;
    assign Co   = r_co;
    assign Zero = w_all_zero;

endmodule
`default_nettype wire

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised multi-mode register: the next-generation storage element for the simpleCPU datapath, replacing single-bit D flip-flops in accumulator, shift and counter roles.
- Modes on each rising clock edge:
  - hold
  - parallel load
  - logical shift left/right with serial input
  - rotate left/right
  - increment/decrement
- Provides true and complement outputs, a registered carry/shift-out flag and a zero flag.

Parameters:
- WIDTH, 8, register width in bits. Legal range is WIDTH >= 1.
- RESET_VAL, 0, value loaded into Q on reset. Width is WIDTH; it is truncated to WIDTH bits.

Ports:
- Clk   input   1      system clock; all state updates on the rising edge.
- Rst   input   1      reset, synchronous, active-high.
- En    input   1      enable. When 0, all state holds regardless of Mode.
- Mode  input   3      operation select (encoding in Behaviour).
- D     input   WIDTH  parallel load data.
- SinL  input   1      serial-in bit entering bit 0 on shift left.
- SinR  input   1      serial-in bit entering bit WIDTH-1 on shift right.
- Q     output  WIDTH  register contents.
- Qn    output  WIDTH  bitwise complement of Q (combinational from Q).
- Co    output  1      registered carry / borrow / shifted-out bit.
- Zero  output  1      1 when Q == 0 (combinational from Q).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-high; sampled only on the rising Clk edge.
- Priority at each rising edge: Rst > En==0 > Mode.
- Reset values: Q = RESET_VAL[WIDTH-1:0], Co = 0. Therefore Qn = ~RESET_VAL and Zero = (RESET_VAL == 0).
- En == 0: Q and Co keep their values; Mode, D, SinL and SinR are ignored.
- Mode encoding when En == 1 (next Q / next Co):
  - 000 HOLD: Q unchanged, Co unchanged.
  - 001 LOAD: Q = D, Co = 0.
  - 010 SHL: Q = {Q[WIDTH-2:0], SinL}, Co = Q[WIDTH-1].
  - 011 SHR: Q = {SinR, Q[WIDTH-1:1]}, Co = Q[0].
  - 100 ROL: Q = {Q[WIDTH-2:0], Q[WIDTH-1]}, Co = Q[WIDTH-1].
  - 101 ROR: Q = {Q[0], Q[WIDTH-1:1]}, Co = Q[0].
  - 110 INC: Q = Q + 1 mod 2^WIDTH, Co = 1 only when old Q was all ones (wrap to 0), else 0.
  - 111 DEC: Q = Q - 1 mod 2^WIDTH, Co = 1 only when old Q was 0 (wrap to all ones), else 0.
- WIDTH == 1 special cases:
  - SHL gives Q = SinL; SHR gives Q = SinR.
  - ROL and ROR leave Q unchanged, with Co = Q.
  - INC and DEC both toggle Q; Co follows the wrap rules above.
  - The implementation must not elaborate zero-width or negative part-selects.
- Latency:
  - Q and Co reflect an operation one edge after it is sampled.
  - Qn and Zero follow Q within the same cycle, with no extra register.
- Inputs are sampled only at the rising edge. Changes to D, SinL, SinR or Mode between edges have no effect on Q.
- Reset asserted mid-sequence, e.g. during an INC run, wins on that edge. Counting resumes from RESET_VAL on the first edge with Rst == 0 and En == 1.
- No internal state other than Q and Co. There are no X outputs after the first reset edge.

Test Plan:
- Reset with RESET_VAL=8'hA5 -> after the edge Q=8'hA5, Qn=8'h5A, Co=0, Zero=0. Then En=0 with Mode=001, D=8'h00 for 3 edges -> Q stays 8'hA5.
- LOAD D=8'h81, then SHL with SinL=1 -> Q=8'h03, Co=1. Then SHR with SinR=0 -> Q=8'h01, Co=1. Then ROR -> Q=8'h80, Co=1. Then ROL -> Q=8'h01, Co=1.
- LOAD 8'hFE, then INC twice -> Q=8'hFF with Co=0, then Q=8'h00 with Co=1 and Zero=1. Then DEC -> Q=8'hFF, Co=1, Zero=0.
- Toggle D between rising edges during LOAD (changes at +1 ns and +19 ns of a 20 ns period) -> Q equals only the D value present at each rising edge.
- Assert Rst on the 3rd edge of an INC run starting from 8'h10 -> sequence 8'h11, 8'h12, then RESET_VAL. Rst and En=0 together -> reset still applies.
- WIDTH=1 instance: LOAD 1, then INC -> Q=0, Co=1. Then ROL -> Q=0, Co=0. Then SHR with SinR=1 -> Q=1, Co=0.
